apb_master_mc: RTL and testbench
================================

# apb_master_mc

Parametrised multi-slave APB master that converts a valid/ready command stream into APB SETUP/ACCESS transfers. It decodes the upper address bits to one of NSLV slave selects, muxes the selected slave's PREADY/PRDATA/PSLVERR, and returns a one-cycle response pulse. It supersedes the single-slave 8-bit master between the GPIO/UART bridge logic and the APB peripherals, and adds back-to-back transfers, error reporting and an optional wait-state timeout.

## Interface
Parameters:
- DATA_W, 8, PWDATA/PRDATA width
- ADDR_W, 4, PADDR width; upper SEL_W = max(1,$clog2(NSLV)) bits select the slave
- NSLV, 2, number of slaves (1..16)
- TIMEOUT, 16, ACCESS cycles without PREADY before forced error (≥2)

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR, decode miss or timeout
- PSEL  out  NSLV  one-hot slave select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  transfer direction
- PADDR  out  ADDR_W  transfer address
- PWDATA  out  DATA_W  write data
- PREADY  in  NSLV  per-slave ready
- PSLVERR  in  NSLV  per-slave error
- PRDATA  in  NSLV*DATA_W  per-slave read data, slave k at [k*DATA_W +: DATA_W]

## Operation
- States: IDLE, SETUP, ACCESS (2-bit, registered, async reset to IDLE).
- cmd_ready = (state==IDLE) | (state==ACCESS & done). Combinational; done depends on PREADY.
- On acceptance, PADDR/PWRITE/PWDATA are registered from cmd_* and the next state is SETUP. PWDATA is loaded on writes only; on reads it holds its previous value.
- SETUP: PSEL[idx]=1, PENABLE=0. Always moves to ACCESS.
- ACCESS: PSEL held, PENABLE=1. done = PREADY[idx] | miss | timeout.
  - done with accepted command: go to SETUP.
  - done without a command: go to IDLE, PSEL=0.
  - otherwise stay in ACCESS.
- idx = PADDR[ADDR_W-1 -: SEL_W]. If NSLV==1, idx=0 always.
- miss = idx ≥ NSLV. On a miss, PSEL stays all-zero, PENABLE still pulses for one ACCESS cycle, and the transfer completes with rsp_err=1, rsp_rdata=0.
- On done, the cycle after: rsp_valid=1, rsp_err = PSLVERR[idx] | miss | timeout, and rsp_rdata = PRDATA[idx] for a clean read, else 0.
- No response back-pressure. A consumer must take rsp_* in the rsp_valid cycle.
- Write and read responses are identical in timing.

## Timing
- Reset values: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Zero-wait transfer, command accepted at edge 0:
  - SETUP visible in cycle 1.
  - ACCESS in cycle 2 with PREADY=1.
  - rsp_valid in cycle 3.
  - Total 2 APB cycles per transfer.
- Back-to-back: a command accepted in the done cycle gives SETUP in the next cycle. PENABLE drops for exactly one cycle. PSEL stays high if idx is unchanged, otherwise it switches one-hot in SETUP.
- Each wait state adds one cycle. PADDR, PWRITE, PWDATA and PSEL are stable from SETUP through the last ACCESS cycle.
- Reset asserted mid-transfer: outputs go to reset values immediately (async). No response is issued and the in-flight command is lost.
- PREADY/PSLVERR from unselected slaves are ignored. PSLVERR is sampled only in the done cycle.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter clears in SETUP and increments each ACCESS cycle with PREADY[idx]=0.
  - If the TIMEOUT-th consecutive such cycle is reached, done is forced in that cycle with timeout=1, and the transfer ends with rsp_err=1, rsp_rdata=0.
  - A PREADY arriving later is ignored.
- APB_MASTER_TIMEOUT_EN undefined: the counter logic is absent. ACCESS waits indefinitely for PREADY and timeout is constant 0.

## Test plan
- Write 0xA5 to addr 0x3 (slave 0), PREADY=1: PSEL=01 for 2 cycles, PENABLE only in cycle 2, PWDATA=0xA5, rsp_valid one cycle later with rsp_err=0, rsp_rdata=0.
- Read addr 0xC (slave 1) with 3 wait states, PRDATA slave1=0x5A: ACCESS lasts 4 cycles, rsp_rdata=0x5A, rsp_err=0, PADDR stable throughout.
- Four back-to-back writes alternating slaves with cmd_valid held high: 8 cycles total, PENABLE pattern 0101_0101, four rsp_valid pulses, PSEL switches at each SETUP.
- NSLV=3, read addr 0xF (idx 3, miss): PSEL=000, one ACCESS cycle, rsp_err=1, rsp_rdata=0.
- Slave 0 read with PSLVERR=1 in the ready cycle gives rsp_err=1, rsp_rdata=0. With APB_MASTER_TIMEOUT_EN defined and TIMEOUT=16, PREADY held 0 gives rsp_err=1 after exactly 16 ACCESS cycles.
- Assert PRESETn low during ACCESS: all outputs 0 immediately, no rsp_valid. After release, a fresh read completes normally.

Source files
------------

// File: rtl/apb_master_mc.sv
// apb_master_mc: multi-slave APB master driven by a valid/ready command stream.
// Optional wait-state timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_mc #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [NSLV-1:0]          PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [NSLV-1:0]          PREADY,
  input  logic [NSLV-1:0]          PSLVERR,
  input  logic [NSLV*DATA_W-1:0]   PRDATA,
  output logic [1:0]               state_dbg
);

  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  generate
    if (NSLV < 1 || NSLV > 16 || TIMEOUT < 2) begin : g_bad_param
      $error("apb_master_mc: NSLV must be 1..16 and TIMEOUT at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]  idx;
  logic [4:0]        idx_ext;
  logic              miss;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout;
  logic              done;
  logic              accept;
  logic              rsp_bad;

  generate
    if (NSLV == 1) begin : g_one_slave
      assign idx = '0;
    end else begin : g_multi_slave
      assign idx = PADDR[ADDR_W-1 -: SEL_W];
    end
  endgenerate

  assign idx_ext = 5'(idx);
  assign miss    = (idx_ext >= 5'(NSLV));

  // A decode miss matches no slave, so PSEL stays zero and the selected
  // PREADY/PSLVERR/PRDATA all read as zero.
  always_comb begin
    PSEL      = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_ext == 5'(k)) begin
        PSEL[k]   = (state != IDLE);
        sel_ready = PREADY[k];
        sel_err   = PSLVERR[k];
        sel_rdata = PRDATA[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !sel_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th consecutive ACCESS cycle without PREADY.
  assign timeout = (state == ACCESS) && !sel_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done    = (state == ACCESS) && (sel_ready || miss || timeout);
  assign rsp_bad = sel_err || miss || timeout;

  // Handshake: a command transfers on a PCLK edge where cmd_valid && cmd_ready;
  // cmd_* must hold while cmd_valid is high and cmd_ready low. cmd_ready is
  // combinational (it follows PREADY in the final ACCESS cycle). rsp_* has no
  // ready and is valid for exactly the one cycle rsp_valid is high.
  assign cmd_ready = (state == IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        if (cmd_write) PWDATA <= cmd_wdata;
      end
      // PWRITE still describes the finishing transfer here.
      rsp_valid <= done;
      rsp_err   <= done && rsp_bad;
      rsp_rdata <= (done && !PWRITE && !rsp_bad) ? sel_rdata : '0;
    end
  end

  assign PENABLE   = (state == ACCESS);
  assign state_dbg = state;

endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc: directed and randomized transfers against a transaction-level
// model of a three-slave APB bus (each slave owns one quarter of the address space).
module tb_apb_master_mc;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int NSLV    = 3;
  localparam int TIMEOUT = 16;
  localparam int EXP_W   = DATA_W + 1;
  localparam int BOUND   = 3000;

  // clock / reset
  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  logic                   cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [DATA_W-1:0]      cmd_wdata;
  logic                   rsp_valid, rsp_err;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [NSLV-1:0]        PSEL;
  logic                   PENABLE, PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic [NSLV-1:0]        PREADY, PSLVERR;
  logic [NSLV*DATA_W-1:0] PRDATA;
  logic [1:0]             state_dbg;

  apb_master_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pw;
    int                waits;
    logic              serr;
    logic [DATA_W-1:0] rdata;
    int                gap;
  } txn_t;

  // scoreboard state
  logic [EXP_W-1:0]  exp_q[$];
  txn_t              src_q[$];
  txn_t              txn_q[$];
  txn_t              cur;
  txn_t              pcmd;
  bit                pend, in_acc, rsp_due;
  int                acc_cnt, cur_len, gap_left;
  logic [DATA_W-1:0] last_wd;
  logic [NSLV-1:0]   prev_psel;
  logic [ADDR_W-1:0] prev_paddr;
  int                n_checks = 0;
  int                n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: slave number is the top quarter of the 16-entry space
  function automatic int slave_of(input logic [ADDR_W-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic bit is_miss(input logic [ADDR_W-1:0] a);
    return slave_of(a) >= NSLV;
  endfunction

  function automatic bit is_timeout(input txn_t t);
`ifdef APB_MASTER_TIMEOUT_EN
    return !is_miss(t.addr) && (t.waits >= TIMEOUT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int run_len(input txn_t t);
    if (is_miss(t.addr)) return 1;
    if (is_timeout(t)) return TIMEOUT;
    return t.waits + 1;
  endfunction

  function automatic logic [NSLV-1:0] exp_psel(input txn_t t);
    logic [NSLV-1:0] s;
    s = '0;
    if (!is_miss(t.addr)) s[slave_of(t.addr)] = 1'b1;
    return s;
  endfunction

  function automatic txn_t make_txn(input logic [ADDR_W-1:0] a, input logic w,
                                    input logic [DATA_W-1:0] wd, input int waits,
                                    input logic serr, input logic [DATA_W-1:0] rd,
                                    input int gap);
    txn_t t;
    t.addr = a; t.write = w; t.wdata = wd; t.pw = '0; t.waits = waits;
    t.serr = serr; t.rdata = rd; t.gap = gap;
    return t;
  endfunction

  // driver tasks
  task automatic drive_slaves();
    int s;
    PREADY  = NSLV'($urandom);
    PSLVERR = NSLV'($urandom);
    for (int k = 0; k < NSLV; k++) PRDATA[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    if (PENABLE && in_acc && !is_miss(cur.addr)) begin
      s = slave_of(cur.addr);
      PREADY[s] = (acc_cnt >= cur.waits);
      if (acc_cnt >= cur.waits) PSLVERR[s] = cur.serr;
      PRDATA[s*DATA_W +: DATA_W] = cur.rdata;
    end
  endtask

  task automatic drive_cmd();
    if (!pend && src_q.size() > 0) begin
      pcmd = src_q.pop_front();
      gap_left = pcmd.gap;
      pend = 1'b1;
    end
    if (pend && gap_left == 0) begin
      cmd_valid = 1'b1;
      cmd_addr  = pcmd.addr;
      cmd_write = pcmd.write;
      cmd_wdata = pcmd.wdata;
    end else begin
      if (pend) gap_left--;
      cmd_valid = 1'b0;
      cmd_addr  = ADDR_W'($urandom);
      cmd_write = 1'($urandom);
      cmd_wdata = DATA_W'($urandom);
    end
  endtask

  task automatic accept_cmd();
    txn_t t;
    logic err;
    logic [DATA_W-1:0] rd;
    t = pcmd;
    if (t.write) last_wd = t.wdata;
    t.pw = last_wd;
    err = is_miss(t.addr) || is_timeout(t) || t.serr;
    rd  = (!t.write && !err) ? t.rdata : '0;
    txn_q.push_back(t);
    exp_q.push_back({err, rd});
    pend = 1'b0;
  endtask

  // one clock: check what the last edge produced, drive the next edge
  task automatic step();
    logic [EXP_W-1:0] e;
    logic exp_rdy;
    @(negedge PCLK);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
    if (rsp_valid && rsp_due && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("rsp_err", 32'(rsp_err), 32'(e[DATA_W]));
      check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e[DATA_W-1:0]));
    end
    rsp_due = 1'b0;
    if (PENABLE) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        acc_cnt = 0;
        check_eq("access_has_cmd", 32'(txn_q.size() > 0), 32'd1);
        if (txn_q.size() > 0) cur = txn_q.pop_front();
        cur_len = run_len(cur);
        check_eq("setup_psel", 32'(prev_psel), 32'(exp_psel(cur)));
        check_eq("setup_paddr", 32'(prev_paddr), 32'(cur.addr));
      end else begin
        acc_cnt++;
      end
      check_eq("psel", 32'(PSEL), 32'(exp_psel(cur)));
      check_eq("paddr", 32'(PADDR), 32'(cur.addr));
      check_eq("pwrite", 32'(PWRITE), 32'(cur.write));
      check_eq("pwdata", 32'(PWDATA), 32'(cur.pw));
      if (acc_cnt == cur_len - 1) rsp_due = 1'b1;
    end else begin
      in_acc = 1'b0;
    end
    prev_psel  = PSEL;
    prev_paddr = PADDR;
    exp_rdy = (txn_q.size() == 0 && !in_acc) || rsp_due;
    drive_slaves();
    drive_cmd();
    #1;
    check_eq("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    if (cmd_valid && cmd_ready) accept_cmd();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pend || src_q.size() > 0 || txn_q.size() > 0 || exp_q.size() > 0 ||
            in_acc || rsp_due) && n < BOUND) begin
      step();
      n++;
    end
    check_eq(tag, 32'(n < BOUND), 32'd1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    src_q.delete();
    txn_q.delete();
    pend = 1'b0; in_acc = 1'b0; rsp_due = 1'b0;
    acc_cnt = 0; cur_len = 1; gap_left = 0;
    last_wd = '0; prev_psel = '0; prev_paddr = '0;
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_psel"},    32'(PSEL), 32'd0);
    check_eq({tag, "_penable"}, 32'(PENABLE), 32'd0);
    check_eq({tag, "_pwrite"},  32'(PWRITE), 32'd0);
    check_eq({tag, "_paddr"},   32'(PADDR), 32'd0);
    check_eq({tag, "_pwdata"},  32'(PWDATA), 32'd0);
    check_eq({tag, "_rsp"},     32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
  endtask

  initial begin
    int n;
    int w;
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    clear_model();
    cur = make_txn('0, 1'b0, '0, 0, 1'b0, '0, 0);
    #12;
    check_reset_outputs("reset");
    check_eq("reset_state", 32'(state_dbg), 32'd0);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    #1 PRESETn = 1'b1;

    // directed: write to slave 0, wait-state read from slave 1
    src_q.push_back(make_txn(4'h3, 1'b1, 8'hA5, 0, 1'b0, 8'h00, 0));
    drain("drain_write");
    src_q.push_back(make_txn(4'h5, 1'b0, 8'h00, 3, 1'b0, 8'h5A, 0));
    drain("drain_read_waits");
    // back-to-back writes alternating slaves
    src_q.push_back(make_txn(4'h1, 1'b1, 8'h11, 0, 1'b0, 8'h00, 0));
    src_q.push_back(make_txn(4'h6, 1'b1, 8'h22, 0, 1'b0, 8'h00, 0));
    src_q.push_back(make_txn(4'h2, 1'b1, 8'h33, 0, 1'b0, 8'h00, 0));
    src_q.push_back(make_txn(4'h9, 1'b1, 8'h44, 0, 1'b0, 8'h00, 0));
    drain("drain_b2b");
    // decode miss, slave error, and the timeout boundary
    src_q.push_back(make_txn(4'hF, 1'b0, 8'h00, 0, 1'b0, 8'hEE, 0));
    src_q.push_back(make_txn(4'h0, 1'b0, 8'h00, 1, 1'b1, 8'h99, 0));
    src_q.push_back(make_txn(4'h8, 1'b0, 8'h00, TIMEOUT - 1, 1'b0, 8'h6B, 0));
    src_q.push_back(make_txn(4'hA, 1'b0, 8'h00, TIMEOUT + 4, 1'b0, 8'h6C, 0));
    drain("drain_errors");

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1))
                                     : int'($urandom_range(0, 3));
      src_q.push_back(make_txn(ADDR_W'($urandom), 1'($urandom), DATA_W'($urandom), w,
                               1'($urandom_range(0, 3) == 0), DATA_W'($urandom),
                               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0));
    end
    drain("drain_random");

    // reset in the middle of an ACCESS phase
    src_q.push_back(make_txn(4'h9, 1'b1, 8'hC3, 6, 1'b0, 8'h00, 0));
    n = 0;
    while (!PENABLE && n < 50) begin
      step();
      n++;
    end
    check_eq("mid_reset_reached_access", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    clear_model();
    repeat (3) step();
    PRESETn = 1'b1;
    src_q.push_back(make_txn(4'h2, 1'b0, 8'h00, 1, 1'b0, 8'h3C, 0));
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
